// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_WAIT_BUS,
    ST_WAIT_PERIPH,
    ST_WAIT_CORE,
    ST_RUN,
    ST_SW_RST,
    ST_DBG_HOLD,
    ST_DBG_REL
  } rst_state_e;

  localparam logic [1:0] RST_CAUSE_POR  = 2'd0;
  localparam logic [1:0] RST_CAUSE_LOCK = 2'd1;
  localparam logic [1:0] RST_CAUSE_SW   = 2'd2;
  localparam logic [1:0] RST_CAUSE_DBG  = 2'd3;

  // Largest of the four delays; the counter must be able to hold it.
  function automatic int unsigned max_dly(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rst_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level, cleared by reset.
module rst_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d;
  end

  // Synchroniser chain register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: bus, then peripherals/porst, then core release,
// with software system reset, debug core-only reset and reset-cause capture.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BUS_DLY     = 16,
  parameter int unsigned PERIPH_DLY  = 16,
  parameter int unsigned CORE_DLY    = 32,
  parameter int unsigned SWRST_LEN   = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked_in,
  input  logic       sw_rst_req,
  input  logic       dbg_core_rst_req,
  output logic       bus_rst_l,
  output logic       periph_rst_l,
  output logic       core_porst_l,
  output logic       core_rst_l,
  output logic       rst_done,
  output logic [1:0] rst_cause
);

  if (SYNC_STAGES == 0 || BUS_DLY == 0 || PERIPH_DLY == 0 || CORE_DLY == 0 || SWRST_LEN == 0) begin : g_bad_dly
    $error("rst_sequencer: SYNC_STAGES and all delays must be non-zero");
  end
  if ((max_dly(BUS_DLY, PERIPH_DLY, CORE_DLY, SWRST_LEN) >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("rst_sequencer: CNT_W too narrow for the configured delays");
  end

  localparam logic [CNT_W-1:0] BUS_LAST    = CNT_W'(BUS_DLY - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DLY - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DLY - 1);
  localparam logic [CNT_W-1:0] SWRST_LAST  = CNT_W'(SWRST_LEN - 1);

  logic             locked_s;
  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       cause_q, cause_d;
  logic             bus_q, bus_d, periph_q, periph_d, porst_q, porst_d;
  logic             core_q, core_d, done_q, done_d;

  rst_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (reset),
    .d   (locked_in),
    .q   (locked_s)
  );

  // Next-state, counter and registered-output logic; lock loss outranks everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    bus_d    = bus_q;
    periph_d = periph_q;
    porst_d  = porst_q;
    core_d   = core_q;
    done_d   = done_q;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    if (state_q != ST_ASSERT && !locked_s) begin
      {bus_d, periph_d, porst_d, core_d, done_d} = '0;
      cause_d = RST_CAUSE_LOCK;
      cnt_d   = '0;
      state_d = ST_ASSERT;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          {bus_d, periph_d, porst_d, core_d, done_d} = '0;
          if (locked_s) begin
            cnt_d   = '0;
            state_d = ST_WAIT_BUS;
          end
        end
        ST_WAIT_BUS: begin
          if (cnt_q == BUS_LAST) begin
            bus_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_WAIT_PERIPH;
          end else cnt_d = cnt_inc;
        end
        ST_WAIT_PERIPH: begin
          if (cnt_q == PERIPH_LAST) begin
            periph_d = 1'b1;
            porst_d  = 1'b1;
            cnt_d    = '0;
            state_d  = ST_WAIT_CORE;
          end else cnt_d = cnt_inc;
        end
        ST_WAIT_CORE, ST_DBG_REL: begin
          // Core release is shared; DBG_REL additionally yields to sw and debug.
          if (state_q == ST_DBG_REL && sw_rst_req) begin
            {bus_d, periph_d, porst_d, core_d, done_d} = '0;
            cause_d = RST_CAUSE_SW;
            cnt_d   = '0;
            state_d = ST_SW_RST;
          end else if (state_q == ST_DBG_REL && dbg_core_rst_req) begin
            cnt_d   = '0;
            state_d = ST_DBG_HOLD;
          end else if (cnt_q == CORE_LAST) begin
            core_d  = 1'b1;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else cnt_d = cnt_inc;
        end
        ST_RUN: begin
          if (sw_rst_req) begin
            {bus_d, periph_d, porst_d, core_d, done_d} = '0;
            cause_d = RST_CAUSE_SW;
            cnt_d   = '0;
            state_d = ST_SW_RST;
          end else if (dbg_core_rst_req) begin
            core_d  = 1'b0;
            done_d  = 1'b0;
            cause_d = RST_CAUSE_DBG;
            state_d = ST_DBG_HOLD;
          end
        end
        ST_SW_RST: begin
          if (cnt_q == SWRST_LAST) begin
            cnt_d   = '0;
            state_d = ST_ASSERT;
          end else cnt_d = cnt_inc;
        end
        ST_DBG_HOLD: begin
          if (sw_rst_req) begin
            {bus_d, periph_d, porst_d, core_d, done_d} = '0;
            cause_d = RST_CAUSE_SW;
            cnt_d   = '0;
            state_d = ST_SW_RST;
          end else if (!dbg_core_rst_req) begin
            cnt_d   = '0;
            state_d = ST_DBG_REL;
          end
        end
        default: state_d = ST_ASSERT;
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ASSERT;
      cnt_q    <= '0;
      cause_q  <= RST_CAUSE_POR;
      bus_q    <= 1'b0;
      periph_q <= 1'b0;
      porst_q  <= 1'b0;
      core_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      bus_q    <= bus_d;
      periph_q <= periph_d;
      porst_q  <= porst_d;
      core_q   <= core_d;
      done_q   <= done_d;
    end
  end

  assign bus_rst_l    = bus_q;
  assign periph_rst_l = periph_q;
  assign core_porst_l = porst_q;
  assign core_rst_l   = core_q;
  assign rst_done     = done_q;
  assign rst_cause    = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: directed vector table, hand-written
// async-reset sequence, then randomized traffic against a countdown model.
module tb_rst_sequencer;

  localparam int SYNC   = 2;
  localparam int BUSD   = 16;
  localparam int PERD   = 16;
  localparam int CORED  = 32;
  localparam int SWLEN  = 8;

  logic       clk = 1'b0;
  logic       reset, locked_in, sw_rst_req, dbg_core_rst_req;
  logic       bus_rst_l, periph_rst_l, core_porst_l, core_rst_l, rst_done;
  logic [1:0] rst_cause;

  int total = 0;
  int bad   = 0;

  rst_sequencer #(
    .SYNC_STAGES (SYNC),
    .BUS_DLY     (BUSD),
    .PERIPH_DLY  (PERD),
    .CORE_DLY    (CORED),
    .SWRST_LEN   (SWLEN),
    .CNT_W       (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .locked_in        (locked_in),
    .sw_rst_req       (sw_rst_req),
    .dbg_core_rst_req (dbg_core_rst_req),
    .bus_rst_l        (bus_rst_l),
    .periph_rst_l     (periph_rst_l),
    .core_porst_l     (core_porst_l),
    .core_rst_l       (core_rst_l),
    .rst_done         (rst_done),
    .rst_cause        (rst_cause)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // Tracks which stages are released and a countdown to the next release.
  bit m_sync [SYNC];
  bit m_bus, m_per, m_porst, m_core, m_done;
  bit [1:0] m_cause;
  bit m_wait_lock, m_dbg_phase, m_dbg_hold;
  int m_left, m_sw_left;

  task automatic model_reset();
    foreach (m_sync[i]) m_sync[i] = 1'b0;
    {m_bus, m_per, m_porst, m_core, m_done} = '0;
    m_cause = 2'd0;
    m_wait_lock = 1'b1;
    m_dbg_phase = 1'b0;
    m_dbg_hold  = 1'b0;
    m_left = 0;
    m_sw_left = 0;
  endtask

  task automatic model_drop_all();
    {m_bus, m_per, m_porst, m_core, m_done} = '0;
    m_dbg_phase = 1'b0;
    m_dbg_hold  = 1'b0;
    m_left = 0;
  endtask

  task automatic model_release_next();
    if (!m_bus) begin
      m_bus = 1'b1; m_left = PERD;
    end else if (!m_per) begin
      m_per = 1'b1; m_porst = 1'b1; m_left = CORED;
    end else begin
      m_core = 1'b1; m_done = 1'b1; m_dbg_phase = 1'b0;
    end
  endtask

  // One rising edge worth of behaviour, using the inputs present before it.
  task automatic model_step();
    bit ls;
    ls = m_sync[SYNC-1];
    for (int i = SYNC-1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = locked_in;
    if (reset) begin
      model_reset();
    end else if (!m_wait_lock && !ls) begin
      model_drop_all();
      m_cause = 2'd1; m_wait_lock = 1'b1; m_sw_left = 0;
    end else if (m_wait_lock) begin
      if (ls) begin m_wait_lock = 1'b0; m_left = BUSD; end
    end else if (m_sw_left > 0) begin
      m_sw_left--;
      if (m_sw_left == 0) m_wait_lock = 1'b1;
    end else if (sw_rst_req && (m_done || m_dbg_phase)) begin
      model_drop_all();
      m_cause = 2'd2; m_sw_left = SWLEN;
    end else if (m_done) begin
      if (dbg_core_rst_req) begin
        m_core = 1'b0; m_done = 1'b0; m_cause = 2'd3;
        m_dbg_phase = 1'b1; m_dbg_hold = 1'b1;
      end
    end else if (m_dbg_hold) begin
      if (!dbg_core_rst_req) begin m_dbg_hold = 1'b0; m_left = CORED; end
    end else if (m_dbg_phase && dbg_core_rst_req) begin
      m_dbg_hold = 1'b1; m_left = 0;
    end else begin
      m_left--;
      if (m_left == 0) model_release_next();
    end
  endtask

  function automatic logic [6:0] model_vec();
    return {m_bus, m_per, m_porst, m_core, m_done, m_cause};
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [6:0] dut_vec();
    return {bus_rst_l, periph_rst_l, core_porst_l, core_rst_l, rst_done, rst_cause};
  endfunction

  task automatic check(input string nm, input logic [6:0] exp);
    logic [6:0] got;
    got = dut_vec();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got {bus,per,porst,core,done,cause}=%b expected=%b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    int unsigned n;
    logic lk, sw, dbg;
    logic [6:0] exp;
  } vec_t;

  function automatic vec_t mk(input int unsigned n, input logic lk, input logic sw, input logic dbg,
                              input logic [4:0] outs, input logic [1:0] cause);
    vec_t v;
    v.n = n; v.lk = lk; v.sw = sw; v.dbg = dbg; v.exp = {outs, cause};
    return v;
  endfunction

  localparam logic [4:0] A0  = 5'b00000;
  localparam logic [4:0] B1  = 5'b10000;
  localparam logic [4:0] BP  = 5'b11100;
  localparam logic [4:0] ALL = 5'b11111;

  vec_t tbl [$];
  int   lock_low, rst_hold;

  initial begin
    // POR sequence, lock loss, software reset, debug reset, simultaneous events.
    tbl.push_back(mk(10, 0, 0, 0, A0, 0));
    tbl.push_back(mk(18, 1, 0, 0, A0, 0));
    tbl.push_back(mk(1,  1, 0, 0, B1, 0));
    tbl.push_back(mk(15, 1, 0, 0, B1, 0));
    tbl.push_back(mk(1,  1, 0, 0, BP, 0));
    tbl.push_back(mk(31, 1, 0, 0, BP, 0));
    tbl.push_back(mk(1,  1, 0, 0, ALL, 0));
    tbl.push_back(mk(5,  1, 0, 0, ALL, 0));
    tbl.push_back(mk(2,  0, 0, 0, ALL, 0));
    tbl.push_back(mk(1,  0, 0, 0, A0, 1));
    tbl.push_back(mk(1,  0, 0, 0, A0, 1));
    tbl.push_back(mk(18, 1, 0, 0, A0, 1));
    tbl.push_back(mk(1,  1, 0, 0, B1, 1));
    tbl.push_back(mk(16, 1, 0, 0, BP, 1));
    tbl.push_back(mk(32, 1, 0, 0, ALL, 1));
    tbl.push_back(mk(1,  1, 1, 0, A0, 2));
    tbl.push_back(mk(7,  1, 0, 0, A0, 2));
    tbl.push_back(mk(5,  1, 0, 0, A0, 2));
    tbl.push_back(mk(1,  1, 1, 0, A0, 2));
    tbl.push_back(mk(11, 1, 0, 0, A0, 2));
    tbl.push_back(mk(1,  1, 0, 0, B1, 2));
    tbl.push_back(mk(16, 1, 0, 0, BP, 2));
    tbl.push_back(mk(32, 1, 0, 0, ALL, 2));
    tbl.push_back(mk(1,  1, 0, 1, BP, 3));
    tbl.push_back(mk(19, 1, 0, 1, BP, 3));
    tbl.push_back(mk(32, 1, 0, 0, BP, 3));
    tbl.push_back(mk(1,  1, 0, 0, ALL, 3));
    tbl.push_back(mk(1,  1, 1, 1, A0, 2));
    tbl.push_back(mk(7,  1, 0, 0, A0, 2));
    tbl.push_back(mk(66, 1, 0, 0, ALL, 2));
    tbl.push_back(mk(2,  0, 0, 0, ALL, 2));
    tbl.push_back(mk(1,  0, 1, 0, A0, 1));
    tbl.push_back(mk(67, 1, 0, 0, ALL, 1));

    reset = 1'b1; locked_in = 1'b0; sw_rst_req = 1'b0; dbg_core_rst_req = 1'b0;
    model_reset();
    #1;
    check("reset_state", {A0, 2'd0});
    repeat (5) tick();
    check("reset_held", {A0, 2'd0});
    reset = 1'b0;

    foreach (tbl[i]) begin
      locked_in = tbl[i].lk; sw_rst_req = tbl[i].sw; dbg_core_rst_req = tbl[i].dbg;
      repeat (tbl[i].n) tick();
      check($sformatf("row%0d", i), tbl[i].exp);
    end
    sw_rst_req = 1'b0; dbg_core_rst_req = 1'b0; locked_in = 1'b1;

    // Async reset landing in WAIT_PERIPH, then a clean restart.
    sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
    repeat (25) tick();
    check("mid_bus_up", {B1, 2'd2});
    repeat (5) tick();
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_async_rst", {A0, 2'd0});
    repeat (2) tick();
    reset = 1'b0;
    repeat (18) tick();
    check("mid_restart_hold", {A0, 2'd0});
    tick();
    check("mid_restart_bus", {B1, 2'd0});

    // Randomized traffic against the model.
    lock_low = 0; rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 1'b0;
      end else if ($urandom_range(0, 1499) == 0) begin
        reset = 1'b1; rst_hold = 2;
        #1;
        model_reset();
        check("rand_async_rst", model_vec());
      end
      if (lock_low > 0) lock_low--;
      else if ($urandom_range(0, 299) == 0) lock_low = $urandom_range(1, 6);
      locked_in  = (lock_low == 0);
      sw_rst_req = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 79) == 0) dbg_core_rst_req = ~dbg_core_rst_req;
      tick();
      check("rand", model_vec());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Sits directly downstream of the board clock/reset generator.
- Runs on its generated clock. Consumes its lock status and raw reset, and produces staged, glitch-free resets for the AXI interconnect, the peripherals and the SweRV core.
- Adds software-requested system reset and debugger-requested core-only reset, and records the cause of the last reset.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for locked_in.
- BUS_DLY, 16, cycles from lock-qualified start to bus_rst_l release.
- PERIPH_DLY, 16, cycles from bus release to periph_rst_l release.
- CORE_DLY, 32, cycles from periph release (or from debug request drop) to core_rst_l release.
- SWRST_LEN, 8, minimum cycles all resets are held after a software request.
- CNT_W, 8, counter width; must hold max(BUS_DLY, PERIPH_DLY, CORE_DLY, SWRST_LEN).

Ports:
- clk  in  1  generated system clock.
- reset  in  1  asynchronous active-high reset.
- locked_in  in  1  clock-generator lock, asynchronous to clk; synchronised internally.
- sw_rst_req  in  1  single-cycle request from the memory-mapped control register.
- dbg_core_rst_req  in  1  level from the debug module; holds the core in reset while high.
- bus_rst_l  out  1  interconnect reset, active-low.
- periph_rst_l  out  1  peripheral reset, active-low.
- core_porst_l  out  1  core power-on reset, active-low.
- core_rst_l  out  1  core reset, active-low.
- rst_done  out  1  high only in RUN.
- rst_cause  out  2  cause of last reset: 0 POR, 1 lock loss, 2 software, 3 debug.

Behaviour:
- Interface (already decided): one clock, clk. Reset is asynchronous and active-high, port reset.
- While reset is high:
  - All _l outputs are 0 and rst_done is 0.
  - rst_cause is 0, the state is ASSERT, the counter is 0 and the synchroniser flops are 0.
- All outputs are driven directly from flops; there is no combinational path to any output.
- locked_s is locked_in after SYNC_STAGES flops.
- States:
  - ASSERT: all resets asserted. Leaves for WAIT_BUS on the first cycle locked_s=1, with the counter cleared.
  - WAIT_BUS: counter increments each cycle. At cnt==BUS_DLY-1, the next edge sets bus_rst_l=1, clears the counter and enters WAIT_PERIPH.
  - WAIT_PERIPH: at cnt==PERIPH_DLY-1, the next edge sets periph_rst_l=1 and core_porst_l=1 and enters WAIT_CORE.
  - WAIT_CORE: at cnt==CORE_DLY-1, the next edge sets core_rst_l=1 and rst_done=1 and enters RUN.
  - RUN: steady state.
  - SW_RST: all resets asserted. Counter runs to SWRST_LEN-1, then enters ASSERT, which is immediately qualified by locked_s.
  - DBG_HOLD: only core_rst_l=0; bus, periph and porst stay released. On dbg_core_rst_req=0, clear the counter and enter DBG_REL.
  - DBG_REL: at cnt==CORE_DLY-1, the next edge sets core_rst_l=1 and enters RUN. If dbg_core_rst_req re-asserts here, return to DBG_HOLD with the counter cleared.
- Lock loss:
  - locked_s=0 in any state other than ASSERT: next edge asserts all resets, sets rst_cause=1 and enters ASSERT.
  - Lock loss has the highest priority.
- sw_rst_req:
  - Honoured in RUN, DBG_HOLD and DBG_REL; sets rst_cause=2 and enters SW_RST.
  - Ignored in ASSERT, WAIT_* and SW_RST, where the request is dropped, not queued.
- dbg_core_rst_req:
  - Sampled in RUN only. Sets rst_cause=3, deasserts rst_done and enters DBG_HOLD.
  - If it is high on RUN entry, DBG_HOLD is taken on the next cycle.
- Simultaneous events: priority is lock loss > sw_rst_req > dbg_core_rst_req.
- Release ordering is strict: bus, then periph together with porst, then core. Assertion is simultaneous for all outputs.
- Counter width: the counter saturates and never wraps. Comparisons are against DLY-1, so DLY=1 gives one cycle. DLY=0 is illegal; an elaboration-time assertion enforces it.
- rst_cause persists until the next reset event and is cleared only by reset.

Decomposition:
- Shared package rst_seq_pkg holds:
  - the state enum typedef;
  - cause encodings RST_CAUSE_POR/LOCK/SW/DBG;
  - a function returning the maximum of the delays, used for the CNT_W check.
- One sub-module, rst_sync_bit: the SYNC_STAGES-deep flop chain with async active-high clear, with attributes marking it as a synchroniser for timing. It is reused for locked_in.

Test Plan:
- POR: reset high 5 cycles, then low; locked_in rises at cycle 10 → bus_rst_l rises 2+16 edges after that, periph_rst_l and core_porst_l 16 later, core_rst_l and rst_done 32 later; rst_cause=0.
- Lock loss in RUN: drop locked_in for 4 cycles → all _l outputs 0 within SYNC_STAGES+1 edges, rst_cause=1; the full 16/16/32 sequence repeats after relock.
- Software reset: 1-cycle sw_rst_req in RUN → all resets 0 for 8 cycles, then the full sequence; rst_cause=2. A second pulse during WAIT_BUS has no effect.
- Debug core reset: dbg_core_rst_req high 20 cycles in RUN → only core_rst_l=0, rst_done=0; core_rst_l returns 32 cycles after the drop; rst_cause=3; bus_rst_l and periph_rst_l never toggle.
- Simultaneous events: sw_rst_req and dbg_core_rst_req in the same RUN cycle → SW_RST taken, rst_cause=2. Lock loss plus sw_rst_req → ASSERT, rst_cause=1.
- Reset mid-sequence: assert reset during WAIT_PERIPH → all outputs low asynchronously, rst_cause=0, and the sequence restarts from ASSERT.
